teclado_matricial: RTL
======================

# teclado_matricial

- Scans a 4x4 membrane keypad, synchronizes and debounces the column inputs, and encodes one key per press.
- Emits a 5-bit key code on `digito` with a one-cycle `cambio_digito` strobe.
- Sits directly upstream of the RGB digit memory and drives its `digito`/`cambio_digito` inputs.
- One strobe per physical press; no auto-repeat.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row stays driven (minimum 4).
- `DEBOUNCE`, default 500000: consecutive stable cycles required for press and for release (minimum 2).
- `clk` in 1: system clock; everything is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `col` in 4: keypad columns, active-low (pulled up externally); asynchronous to `clk`.
- `fila` out 4: keypad row drive, active-low, one-hot-low.
- `digito` out 5: code of the last accepted key.
- `cambio_digito` out 1: one-cycle pulse, high in the cycle `digito` takes a new value.

## Operation
- **Synchronizer:** `col` passes through a 2-flop synchronizer. Every decision below uses the synchronized value `cs`.
- **Key map, row r / col k:**
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: \*, 0, #, D
- **Codes:**
  - Digits 0-9 encode to 5'h00-5'h09.
  - A/B/C/D encode to 5'h0A-5'h0D.
  - \* encodes to 5'h0E and # to 5'h0F.
  - Bit 4 is 0 for every key. 5'h1F means "no key since reset".
- **SCAN:**
  - Row index `r` cycles 0→1→2→3→0. `fila` = ~(4'b0001 << r).
  - A row-period counter counts 0..SCAN_DIV-1. On the last count it samples `cs`:
    - exactly one bit low: latch `r`, the column k and the pattern `cs`; go to DEBOUNCE; do not advance `r`.
    - otherwise (none low, or several low = ghosting/multi-press): advance `r` and restart the counter.
- **DEBOUNCE:**
  - `fila` stays frozen on the latched row.
  - The counter increments each cycle that `cs` equals the latched pattern.
  - Any mismatch returns to SCAN: `r` advances and the counter clears.
  - When the count reaches DEBOUNCE-1 with the pattern still matching: `digito` ← code(r,k), `cambio_digito` = 1 for that single cycle, go to HELD.
- **HELD:**
  - Row stays frozen.
  - The counter counts consecutive cycles with `cs` = 4'hF, and clears on any low bit.
  - When the count reaches DEBOUNCE-1, go to SCAN with `r` advanced.
  - Pressing a second key while held produces nothing.
- **Counter width:** $clog2(max(SCAN_DIV, DEBOUNCE)) bits, shared between states. The counter clears on every state change.

## Timing
- **Reset values:**
  - state = SCAN, r = 0, `fila` = 4'b1110, counter = 0.
  - `digito` = 5'h1F, `cambio_digito` = 0.
  - Both synchronizer stages = 4'hF.
- **Reset mid-operation** (any state, including the strobe cycle) aborts immediately. Next cycle all outputs are at their reset values and no strobe is issued.
- **Latency:** the key is asserted on `col` while its row is driven. `cambio_digito` rises 2 (sync) + up to SCAN_DIV (row sample) + DEBOUNCE cycles later.
- `digito` changes only in the strobe cycle and holds otherwise. A repeated identical key still strobes.
- **Release:** a minimum of DEBOUNCE cycles of all-high `cs` is required before the next press can register.
- **Row switching:** `fila` changes only on SCAN row-period boundaries. `col` settling after a row switch is masked because sampling occurs only at the last count.
- **Bounce:**
  - Pulses shorter than DEBOUNCE during press produce no strobe.
  - Release glitches shorter than DEBOUNCE keep HELD.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=8.
- **Reset:** assert `rst` 3 cycles, `col`=4'hF → `fila`=4'b1110, `digito`=5'h1F, `cambio_digito`=0. Then `fila` rotates 1110→1101→1011→0111 every 4 cycles.
- **Clean press:**
  - Model key "9" (r2,k2): drive `col`[2]=0 whenever `fila`[2]=0.
  - Required: exactly one strobe with `digito`=5'h09, within 2+4+8 cycles of the row-2 window. Then hold 50 cycles and release → no further strobe.
- **Letter/symbol codes:** press A, then #, then D with clean releases → `digito` = 5'h0A, 5'h0F, 5'h0D, one strobe each.
- **Bounce:**
  - Toggle key "1" every 3 cycles for 30 cycles, then hold stable → no strobe during toggling, exactly one strobe (5'h01) after 8 stable cycles.
  - Release glitch low for 4 cycles while held → no second strobe.
- **Multi-key:** "2" and "3" simultaneously on row 0 → no strobe while both are held. Release "3" → one strobe with 5'h02.
- **Reset mid-debounce:** assert `rst` at debounce count 5 of key "5" → no strobe; outputs at reset values. After `rst` drops, the still-held key is detected from SCAN row 0 and strobes 5'h05 once.

Source files
------------

// File: rtl/teclado_matricial.sv
`default_nettype none
// ============================================================================
// Module   : teclado_matricial
// Brief    : 4x4 membrane keypad scanner with column synchronizer, press and
//            release debounce, and a single-strobe 5-bit key encoder.
// Revision : 1.0 - initial release
// ============================================================================
module teclado_matricial #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] fila,
    output logic [4:0] digito,
    output logic       cambio_digito
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] c_scan_last = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] c_deb_last  = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);

    localparam logic [1:0] c_st_scan = 2'd0;
    localparam logic [1:0] c_st_deb  = 2'd1;
    localparam logic [1:0] c_st_held = 2'd2;

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_row;
    logic [1:0]    r_col;
    logic [3:0]    r_pat;

    logic [1:0]    w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [1:0]    w_row_nx;
    logic [1:0]    w_col_nx;
    logic [3:0]    w_pat_nx;
    logic [4:0]    w_dig_nx;
    logic          w_strobe_nx;
    logic [3:0]    w_low;
    logic          w_one_low;
    logic [1:0]    w_col_idx;

    function automatic logic [4:0] key_code(input logic [1:0] row, input logic [1:0] k);
        logic [4:0] code;
        case ({row, k})
            4'h0: code = 5'h01;
            4'h1: code = 5'h02;
            4'h2: code = 5'h03;
            4'h3: code = 5'h0A;
            4'h4: code = 5'h04;
            4'h5: code = 5'h05;
            4'h6: code = 5'h06;
            4'h7: code = 5'h0B;
            4'h8: code = 5'h07;
            4'h9: code = 5'h08;
            4'hA: code = 5'h09;
            4'hB: code = 5'h0C;
            4'hC: code = 5'h0E;
            4'hD: code = 5'h00;
            4'hE: code = 5'h0F;
            default: code = 5'h0D;
        endcase
        return code;
    endfunction

    assign fila = ~(4'b0001 << r_row);

    // Exactly one active column; several at once is treated as ghosting.
    assign w_low     = ~r_sync2;
    assign w_one_low = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);

    always_comb begin
        w_col_idx = 2'd0;
        case (w_low)
            4'b0010: w_col_idx = 2'd1;
            4'b0100: w_col_idx = 2'd2;
            4'b1000: w_col_idx = 2'd3;
            default: w_col_idx = 2'd0;
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_row_nx    = r_row;
        w_col_nx    = r_col;
        w_pat_nx    = r_pat;
        w_dig_nx    = digito;
        w_strobe_nx = 1'b0;
        case (r_state)
            c_st_scan: begin
                if (r_cnt == c_scan_last) begin
                    w_cnt_nx = '0;
                    if (w_one_low) begin
                        w_state_nx = c_st_deb;
                        w_col_nx   = w_col_idx;
                        w_pat_nx   = r_sync2;
                    end else begin
                        w_row_nx = r_row + 2'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_one;
                end
            end
            c_st_deb: begin
                if (r_sync2 != r_pat) begin
                    w_state_nx = c_st_scan;
                    w_row_nx   = r_row + 2'd1;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nx  = c_st_held;
                    w_cnt_nx    = '0;
                    w_dig_nx    = key_code(r_row, r_col);
                    w_strobe_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_one;
                end
            end
            c_st_held: begin
                // Only an unbroken run of all-high columns counts as release.
                if (r_sync2 != 4'hF) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nx = c_st_scan;
                    w_row_nx   = r_row + 2'd1;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nx = c_st_scan;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1       <= 4'hF;
            r_sync2       <= 4'hF;
            r_state       <= c_st_scan;
            r_cnt         <= '0;
            r_row         <= 2'd0;
            r_col         <= 2'd0;
            r_pat         <= 4'hF;
            digito        <= 5'h1F;
            cambio_digito <= 1'b0;
        end else begin
            r_sync1       <= col;
            r_sync2       <= r_sync1;
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_row         <= w_row_nx;
            r_col         <= w_col_nx;
            r_pat         <= w_pat_nx;
            digito        <= w_dig_nx;
            cambio_digito <= w_strobe_nx;
        end
    end

endmodule
`default_nettype wire
